data_bus_buffer_fifo: RTL and testbench
=======================================

Name: data_bus_buffer_fifo

Overview:
- Clocked, parametrised successor to the PIC bidirectional data bus buffer.
- CPU writes (WR_N strobe) are queued in a DEPTH-entry FIFO and drained to internal logic through a valid/ready handshake.
- CPU reads (RD_N strobe) return a snapshot of a read holding register that internal logic loads, with a registered bus-drive enable.
- Sits between the CPU pins and the control/ICW/OCW register logic; the cascade flag can suppress bus drive.

Parameters:
DATA_W, 8, data width of CPU and internal buses
DEPTH, 4, write FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
RD_N  input  1  CPU read strobe, active low
WR_N  input  1  CPU write strobe, active low
CPU_IN_Data  input  DATA_W  CPU write data
CPU_OUT_Data  output  DATA_W  CPU read data, valid while CPU_OUT_En=1
CPU_OUT_En  output  1  tri-state drive enable for the CPU pins
Flag_From_Cascade  input  1  1 = this device must not drive the CPU bus
IN_InternalD  input  DATA_W  internal data for the read holding register
IN_Load  input  1  load IN_InternalD into the holding register
OUT_InternalD  output  DATA_W  FIFO head data
OUT_Valid  output  1  FIFO non-empty
OUT_Ready  input  1  internal consumer accepts the head
Count  output  $clog2(DEPTH)+1  FIFO occupancy
Full  output  1  Count==DEPTH
Overflow  output  1  sticky: a write was dropped
ClrOvf  input  1  clears Overflow
BusErr  output  1  1-cycle pulse: RD_N and WR_N both low

Behaviour:
- Strobes are registered once (rd_q, wr_q); events are detected on these registered copies. A strobe counts as asserted when its registered copy is 0.
- Reset (rst_n=0 at a clk edge) sets: FIFO empty, Count=0, OUT_Valid=0, Full=0, Overflow=0, BusErr=0, CPU_OUT_En=0, CPU_OUT_Data=0, holding register=0, state=IDLE, rd_q=wr_q=1.
- Reset mid-operation aborts the transfer, flushes the FIFO and discards any queued data.
- State machine (IDLE, RD_ACT, WR_ACT):
  - IDLE -> RD_ACT when the registered RD_N is low and the registered WR_N is high.
  - IDLE -> WR_ACT when the registered WR_N is low and the registered RD_N is high.
  - Both low in IDLE: stay in IDLE, pulse BusErr for one cycle, no transfer.
  - RD_ACT -> IDLE when the registered RD_N goes high.
  - WR_ACT -> IDLE when the registered WR_N goes high.
  - The opposite strobe asserted while in RD_ACT or WR_ACT pulses BusErr once and is otherwise ignored.
- Write:
  - The push happens on the IDLE->WR_ACT transition: exactly one push per strobe, regardless of low duration.
  - The pushed data is CPU_IN_Data as it was 1 cycle earlier (registered alongside WR_N).
  - OUT_Valid rises the cycle after the push.
- Pop: occurs when OUT_Valid and OUT_Ready are both 1; OUT_InternalD always shows the head entry.
- Full:
  - A push while Full with no pop is dropped, FIFO contents are unchanged, and Overflow is set.
  - A push while Full with a same-cycle pop is accepted; Count stays at DEPTH.
- Empty: a push and OUT_Ready=1 in the same cycle give no pop, because OUT_Valid is 0 that cycle.
- Pointers wrap modulo DEPTH.
- Count increments or decrements by exactly 1 per push or pop; it is unchanged when both occur.
- ClrOvf has priority lower than a same-cycle overflow event, so Overflow stays set.
- Read:
  - On IDLE->RD_ACT, CPU_OUT_Data captures the holding register.
  - CPU_OUT_En = (state==RD_ACT) & ~Flag_From_Cascade, registered, so the bus is driven 1 cycle after entry to RD_ACT.
  - IN_Load during RD_ACT updates the holding register but not CPU_OUT_Data, which keeps the snapshot.
  - CPU_OUT_En deasserts the cycle after exit from RD_ACT.
  - CPU_OUT_Data holds its last value while idle.
- IN_Load and a read entry in the same cycle: the snapshot takes the old holding register value.

Optional Feature:
- Macro: DATA_BUS_BUFFER_PARITY_EN.
- When defined:
  - Each FIFO entry stores an extra even-parity bit of the written data.
  - New output OUT_Parity [1] accompanies OUT_InternalD.
  - New output ParErr [1] pulses for 1 cycle on any pop whose stored parity mismatches the XOR of the stored data; data is still delivered.
- When undefined: OUT_Parity and ParErr ports and the parity storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then WR_N low for 3 cycles with CPU_IN_Data=8'hA5, OUT_Ready=0 -> Count=1, OUT_Valid=1 and OUT_InternalD=8'hA5 two cycles after WR_N low; exactly one push.
- DEPTH=4: five writes 8'h01..8'h05 with OUT_Ready=0 -> Full=1, Count=4, Overflow=1. Then OUT_Ready=1 -> pops 01,02,03,04 in order, Count back to 0.
- Full FIFO, write 8'h55 in the same cycle as a pop -> accepted, Count stays 4, Overflow unchanged; 8'h55 popped last.
- IN_Load with IN_InternalD=8'hAA, then RD_N low, then IN_Load with 8'h33 while RD_N stays low -> CPU_OUT_Data=8'hAA, CPU_OUT_En=1 throughout; after RD_N high, CPU_OUT_En=0 one cycle later.
- Read with Flag_From_Cascade=1 -> CPU_OUT_En stays 0. RD_N and WR_N low together -> BusErr single-cycle pulse, no push, no read snapshot.
- Assert rst_n=0 during RD_ACT with 2 entries queued -> next cycle CPU_OUT_En=0, Count=0, OUT_Valid=0, Overflow=0.

Source files
------------

// File: rtl/data_bus_buffer_fifo_if.sv
// CPU pin and internal-side bus bundle for data_bus_buffer_fifo.
// The parity signals exist only when DATA_BUS_BUFFER_PARITY_EN is defined.
interface data_bus_buffer_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              RD_N;
    logic              WR_N;
    logic [DATA_W-1:0] CPU_IN_Data;
    logic [DATA_W-1:0] CPU_OUT_Data;
    logic              CPU_OUT_En;
    logic              Flag_From_Cascade;
    logic [DATA_W-1:0] IN_InternalD;
    logic              IN_Load;
    logic [DATA_W-1:0] OUT_InternalD;
    logic              OUT_Valid;
    logic              OUT_Ready;
    logic [CW-1:0]     Count;
    logic              Full;
    logic              Overflow;
    logic              ClrOvf;
    logic              BusErr;
`ifdef DATA_BUS_BUFFER_PARITY_EN
    logic              OUT_Parity;
    logic              ParErr;
`endif

    modport slave (
        input  RD_N, WR_N, CPU_IN_Data, Flag_From_Cascade, IN_InternalD, IN_Load,
               OUT_Ready, ClrOvf,
`ifdef DATA_BUS_BUFFER_PARITY_EN
        output OUT_Parity, ParErr,
`endif
        output CPU_OUT_Data, CPU_OUT_En, OUT_InternalD, OUT_Valid, Count, Full,
               Overflow, BusErr
    );

    modport master (
        output RD_N, WR_N, CPU_IN_Data, Flag_From_Cascade, IN_InternalD, IN_Load,
               OUT_Ready, ClrOvf,
`ifdef DATA_BUS_BUFFER_PARITY_EN
        input  OUT_Parity, ParErr,
`endif
        input  CPU_OUT_Data, CPU_OUT_En, OUT_InternalD, OUT_Valid, Count, Full,
               Overflow, BusErr
    );
endinterface

// File: rtl/data_bus_buffer_fifo.sv
// Clocked CPU data bus buffer: write strobes queue into a FIFO, read strobes snapshot a holding register.
// Optional per-entry even parity is enabled by defining DATA_BUS_BUFFER_PARITY_EN.
module data_bus_buffer_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    data_bus_buffer_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef DATA_BUS_BUFFER_PARITY_EN
    localparam int unsigned EW = DATA_W + 1;
`else
    localparam int unsigned EW = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, RD_ACT, WR_ACT} state_t;

    state_t            state;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] out_data;
    logic              out_en;
    logic              valid;
    logic              full;
    logic              ovf;
    logic              both_q;
    logic              bus_err;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              both_c;
    logic              push_c;
    logic              rd_enter_c;
    logic              pop_c;
    logic              accept_c;
    logic [EW-1:0]     entry_c;
    logic [EW-1:0]     head_c;
    logic [CW-1:0]     count_next_c;

    // Strobe events are decoded from the registered strobe copies only
    assign both_c     = ~rd_q & ~wr_q;
    assign push_c     = (state == IDLE) && !wr_q && rd_q;
    assign rd_enter_c = (state == IDLE) && !rd_q && wr_q;
    assign pop_c      = valid & bus.OUT_Ready;
    assign accept_c   = push_c & (~full | pop_c);
    assign head_c     = mem[rd_ptr];

`ifdef DATA_BUS_BUFFER_PARITY_EN
    logic par_err;
    assign entry_c        = {^din_q, din_q};
    assign bus.OUT_Parity = head_c[DATA_W];
    assign bus.ParErr     = par_err;
    assign bus.OUT_InternalD = head_c[DATA_W-1:0];
`else
    assign entry_c           = din_q;
    assign bus.OUT_InternalD = head_c;
`endif

    always_comb begin
        count_next_c = count;
        if (accept_c && !pop_c) begin
            count_next_c = count + CW'(1);
        end else if (!accept_c && pop_c) begin
            count_next_c = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            din_q    <= '0;
            hold     <= '0;
            out_data <= '0;
            out_en   <= 1'b0;
            valid    <= 1'b0;
            full     <= 1'b0;
            ovf      <= 1'b0;
            both_q   <= 1'b0;
            bus_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef DATA_BUS_BUFFER_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            rd_q    <= bus.RD_N;
            wr_q    <= bus.WR_N;
            din_q   <= bus.CPU_IN_Data;
            both_q  <= both_c;
            // One pulse per overlap episode, whichever strobe came first
            bus_err <= both_c & ~both_q;

            case (state)
                IDLE: begin
                    if (push_c) begin
                        state <= WR_ACT;
                    end else if (rd_enter_c) begin
                        state <= RD_ACT;
                    end
                end
                RD_ACT:  if (rd_q) state <= IDLE;
                WR_ACT:  if (wr_q) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Snapshot reads the pre-load holding value when both happen together
            if (rd_enter_c) out_data <= hold;
            if (bus.IN_Load) hold <= bus.IN_InternalD;
            out_en <= (state == RD_ACT) & ~bus.Flag_From_Cascade;

            if (accept_c) begin
                mem[wr_ptr] <= entry_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            valid <= (count_next_c != '0);
            full  <= (count_next_c == CW'(DEPTH));

            if (push_c && full && !pop_c) begin
                ovf <= 1'b1;
            end else if (bus.ClrOvf) begin
                ovf <= 1'b0;
            end
`ifdef DATA_BUS_BUFFER_PARITY_EN
            par_err <= pop_c & (head_c[DATA_W] != ^head_c[DATA_W-1:0]);
`endif
        end
    end

    assign bus.CPU_OUT_Data = out_data;
    assign bus.CPU_OUT_En   = out_en;
    assign bus.OUT_Valid    = valid;
    assign bus.Count        = count;
    assign bus.Full         = full;
    assign bus.Overflow     = ovf;
    assign bus.BusErr       = bus_err;
endmodule

// File: tb/tb_data_bus_buffer_fifo.sv
// Directed self-checking bench for data_bus_buffer_fifo (DATA_W=8, DEPTH=4).
module tb_data_bus_buffer_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_bus_buffer_fifo_if #(.DATA_W(8), .DEPTH(4)) bus ();

    data_bus_buffer_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.WR_N = 1'b0;
        bus.CPU_IN_Data = d;
        tick();
        bus.WR_N = 1'b1;
        tick(2);
    endtask

    task automatic pop_one(input string name, input logic [7:0] exp);
        checks++;
        if (bus.OUT_Valid !== 1'b1 || bus.OUT_InternalD !== exp) begin
            errors++;
            $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h",
                     name, bus.OUT_Valid, bus.OUT_InternalD, exp);
        end
        bus.OUT_Ready = 1'b1;
        tick();
        bus.OUT_Ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (bus.Count !== 3'd0 || bus.OUT_Valid !== 1'b0 || bus.Full !== 1'b0 ||
            bus.Overflow !== 1'b0 || bus.BusErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo: count=%0d valid=%b full=%b ovf=%b buserr=%b, required all 0",
                     bus.Count, bus.OUT_Valid, bus.Full, bus.Overflow, bus.BusErr);
        end
        checks++;
        if (bus.CPU_OUT_En !== 1'b0 || bus.CPU_OUT_Data !== 8'h00) begin
            errors++;
            $display("FAIL reset_read: en=%b data=%h, required en=0 data=00",
                     bus.CPU_OUT_En, bus.CPU_OUT_Data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        bus.WR_N = 1'b0;
        bus.CPU_IN_Data = 8'hA5;
        tick();
        checks++;
        if (bus.OUT_Valid !== 1'b0) begin
            errors++;
            $display("FAIL write_latency_early: valid=%b, required 0", bus.OUT_Valid);
        end
        tick();
        checks++;
        if (bus.Count !== 3'd1 || bus.OUT_Valid !== 1'b1 || bus.OUT_InternalD !== 8'hA5) begin
            errors++;
            $display("FAIL write_single: count=%0d valid=%b data=%h, required 1 1 a5",
                     bus.Count, bus.OUT_Valid, bus.OUT_InternalD);
        end
        bus.CPU_IN_Data = 8'h5A;
        tick();
        bus.WR_N = 1'b1;
        tick(3);
        checks++;
        if (bus.Count !== 3'd1) begin
            errors++;
            $display("FAIL write_one_push: count=%0d, required 1", bus.Count);
        end
        pop_one("write_pop", 8'hA5);
        checks++;
        if (bus.Count !== 3'd0 || bus.OUT_Valid !== 1'b0) begin
            errors++;
            $display("FAIL write_drain: count=%0d valid=%b, required 0 0", bus.Count, bus.OUT_Valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        checks++;
        if (bus.Full !== 1'b1 || bus.Count !== 3'd4 || bus.Overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state: full=%b count=%0d ovf=%b, required 1 4 1",
                     bus.Full, bus.Count, bus.Overflow);
        end
        for (int i = 1; i <= 4; i++) pop_one("overflow_pop", 8'(i));
        checks++;
        if (bus.Count !== 3'd0 || bus.Full !== 1'b0 || bus.OUT_Valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: count=%0d full=%b valid=%b, required 0 0 0",
                     bus.Count, bus.Full, bus.OUT_Valid);
        end
        checks++;
        if (bus.Overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", bus.Overflow);
        end
        bus.ClrOvf = 1'b1;
        tick();
        bus.ClrOvf = 1'b0;
        checks++;
        if (bus.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b, required 0", bus.Overflow);
        end
    endtask

    task automatic test_full_pop();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        // Push cycle of 8'h55 coincides with a single pop of the head
        bus.WR_N = 1'b0;
        bus.CPU_IN_Data = 8'h55;
        tick();
        bus.WR_N = 1'b1;
        bus.OUT_Ready = 1'b1;
        tick();
        bus.OUT_Ready = 1'b0;
        checks++;
        if (bus.Count !== 3'd4 || bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d full=%b ovf=%b, required 4 1 0",
                     bus.Count, bus.Full, bus.Overflow);
        end
        tick(2);
        pop_one("full_pop_0", 8'h22);
        pop_one("full_pop_1", 8'h33);
        pop_one("full_pop_2", 8'h44);
        pop_one("full_pop_3", 8'h55);
        checks++;
        if (bus.Count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain: count=%0d, required 0", bus.Count);
        end
    endtask

    task automatic test_read();
        bus.IN_Load = 1'b1;
        bus.IN_InternalD = 8'hAA;
        tick();
        bus.IN_Load = 1'b0;
        bus.RD_N = 1'b0;
        tick(2);
        checks++;
        if (bus.CPU_OUT_Data !== 8'hAA || bus.CPU_OUT_En !== 1'b0) begin
            errors++;
            $display("FAIL read_entry: data=%h en=%b, required aa 0", bus.CPU_OUT_Data, bus.CPU_OUT_En);
        end
        tick();
        checks++;
        if (bus.CPU_OUT_En !== 1'b1) begin
            errors++;
            $display("FAIL read_en_rise: en=%b, required 1", bus.CPU_OUT_En);
        end
        bus.IN_Load = 1'b1;
        bus.IN_InternalD = 8'h33;
        tick();
        bus.IN_Load = 1'b0;
        tick();
        checks++;
        if (bus.CPU_OUT_Data !== 8'hAA || bus.CPU_OUT_En !== 1'b1) begin
            errors++;
            $display("FAIL read_snapshot_hold: data=%h en=%b, required aa 1",
                     bus.CPU_OUT_Data, bus.CPU_OUT_En);
        end
        bus.RD_N = 1'b1;
        tick();
        checks++;
        if (bus.CPU_OUT_En !== 1'b1) begin
            errors++;
            $display("FAIL read_en_still_active: en=%b, required 1", bus.CPU_OUT_En);
        end
        tick(2);
        checks++;
        if (bus.CPU_OUT_En !== 1'b0 || bus.CPU_OUT_Data !== 8'hAA) begin
            errors++;
            $display("FAIL read_exit: en=%b data=%h, required 0 aa", bus.CPU_OUT_En, bus.CPU_OUT_Data);
        end
    endtask

    task automatic test_cascade();
        bus.Flag_From_Cascade = 1'b1;
        bus.RD_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.CPU_OUT_En !== 1'b0) begin
                errors++;
                $display("FAIL cascade_no_drive: cycle %0d en=%b, required 0", i, bus.CPU_OUT_En);
            end
        end
        checks++;
        if (bus.CPU_OUT_Data !== 8'h33) begin
            errors++;
            $display("FAIL cascade_snapshot: data=%h, required 33", bus.CPU_OUT_Data);
        end
        bus.RD_N = 1'b1;
        tick(3);
        bus.Flag_From_Cascade = 1'b0;
    endtask

    task automatic test_bus_err();
        bus.IN_Load = 1'b1;
        bus.IN_InternalD = 8'h77;
        tick();
        bus.IN_Load = 1'b0;
        bus.RD_N = 1'b0;
        bus.WR_N = 1'b0;
        bus.CPU_IN_Data = 8'hEE;
        tick();
        checks++;
        if (bus.BusErr !== 1'b0) begin
            errors++;
            $display("FAIL buserr_early: buserr=%b, required 0", bus.BusErr);
        end
        tick();
        checks++;
        if (bus.BusErr !== 1'b1) begin
            errors++;
            $display("FAIL buserr_pulse: buserr=%b, required 1", bus.BusErr);
        end
        tick();
        checks++;
        if (bus.BusErr !== 1'b0) begin
            errors++;
            $display("FAIL buserr_single: buserr=%b, required 0", bus.BusErr);
        end
        tick(2);
        checks++;
        if (bus.Count !== 3'd0 || bus.OUT_Valid !== 1'b0 || bus.CPU_OUT_Data !== 8'h33 ||
            bus.CPU_OUT_En !== 1'b0 || bus.BusErr !== 1'b0) begin
            errors++;
            $display("FAIL buserr_no_transfer: count=%0d valid=%b data=%h en=%b buserr=%b, required 0 0 33 0 0",
                     bus.Count, bus.OUT_Valid, bus.CPU_OUT_Data, bus.CPU_OUT_En, bus.BusErr);
        end
        bus.RD_N = 1'b1;
        bus.WR_N = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_mid();
        write_byte(8'h09);
        write_byte(8'h0A);
        bus.RD_N = 1'b0;
        tick(3);
        checks++;
        if (bus.CPU_OUT_En !== 1'b1 || bus.Count !== 3'd2 || bus.CPU_OUT_Data !== 8'h77) begin
            errors++;
            $display("FAIL reset_mid_setup: en=%b count=%0d data=%h, required 1 2 77",
                     bus.CPU_OUT_En, bus.Count, bus.CPU_OUT_Data);
        end
        rst_n = 1'b0;
        bus.RD_N = 1'b1;
        tick();
        checks++;
        if (bus.CPU_OUT_En !== 1'b0 || bus.Count !== 3'd0 || bus.OUT_Valid !== 1'b0 ||
            bus.Overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: en=%b count=%0d valid=%b ovf=%b, required 0 0 0 0",
                     bus.CPU_OUT_En, bus.Count, bus.OUT_Valid, bus.Overflow);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (bus.Count !== 3'd0 || bus.OUT_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flushed: count=%0d valid=%b, required 0 0", bus.Count, bus.OUT_Valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.RD_N = 1'b1;
        bus.WR_N = 1'b1;
        bus.CPU_IN_Data = 8'h00;
        bus.Flag_From_Cascade = 1'b0;
        bus.IN_InternalD = 8'h00;
        bus.IN_Load = 1'b0;
        bus.OUT_Ready = 1'b0;
        bus.ClrOvf = 1'b0;

        test_reset();
        test_single_write();
        test_overflow();
        test_full_pop();
        test_read();
        test_cascade();
        test_bus_err();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
